bus_bridge_req_arbiter: RTL and testbench

- Shares one bus-bridge initiator request/response channel between NUM_REQ local requesters.
- Sits between the requesters and the bus bridge initiator interface.
- Round-robin arbitration; one outstanding transaction at a time.
- Each response is routed back only to the requester that issued the request.
- All downstream payloads are registered; requester payloads use bus_bridge_req_t / bus_bridge_resp_t from bus_bridge_pkg.

---
 rtl/bus_bridge_pkg.sv | 20 ++
 rtl/bus_bridge_req_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_bus_bridge_req_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_bridge_pkg.sv
// Shared payload types for the bus-bridge initiator channel.
//   bus_bridge_req_t  : address, write data and direction of one request
//   bus_bridge_resp_t : read data and an echo of the request direction
package bus_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] write_data;
        logic              is_write;
    } bus_bridge_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] read_data;
        logic              is_write;
    } bus_bridge_resp_t;

endpackage

// File: rtl/bus_bridge_req_arbiter.sv
// bus_bridge_req_arbiter
//   Shares one bus-bridge initiator request/response channel between NUM_REQ
//   local requesters. Round-robin arbitration, a single outstanding
//   transaction, and the response is routed back to the requester that
//   issued the request. Downstream request and upstream response payloads
//   are registered.
//
// Parameters
//   NUM_REQ : number of requesters, 1..16
//   ID_W    : width of owner_id, $clog2(NUM_REQ) with a minimum of 1
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   up_req_valid     : per-requester request valid
//   up_req_ready     : per-requester accept, at most one bit high
//   up_req_payload   : per-requester request payload
//   up_resp_valid    : per-requester response valid, at most one bit high
//   up_resp_ready    : per-requester response accept
//   up_resp_payload  : shared response payload, qualified by up_resp_valid
//   dn_req_valid     : request valid to the bridge initiator
//   dn_req_ready     : bridge initiator ready
//   dn_req_payload   : registered request to the bridge
//   dn_resp_valid    : bridge response valid
//   dn_resp_ready    : response accept to the bridge
//   dn_resp_payload  : bridge response payload
//   owner_id         : index of the current / last granted requester
//   busy             : high whenever a transaction is in flight
module bus_bridge_req_arbiter
    import bus_bridge_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   up_req_valid,
    output logic [NUM_REQ-1:0]   up_req_ready,
    input  bus_bridge_req_t      up_req_payload [NUM_REQ],
    output logic [NUM_REQ-1:0]   up_resp_valid,
    input  logic [NUM_REQ-1:0]   up_resp_ready,
    output bus_bridge_resp_t     up_resp_payload,
    output logic                 dn_req_valid,
    input  logic                 dn_req_ready,
    output bus_bridge_req_t      dn_req_payload,
    input  logic                 dn_resp_valid,
    output logic                 dn_resp_ready,
    input  bus_bridge_resp_t     dn_resp_payload,
    output logic [ID_W-1:0]      owner_id,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_RESP = 2'd2,
        ARB_RESP      = 2'd3
    } arb_state_t;

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [NUM_REQ-1:0] owner_oh;
    logic               accept;
    logic               issue_hs;
    logic               resp_cap;
    logic               resp_done;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    // Result is {found, index}. A mask test is used instead of a variable
    // bit-select so the search index can stay a plain int.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!res[ID_W] && |(vld & (NUM_REQ'(1) << idx))) begin
                res[ID_W]       = 1'b1;
                res[ID_W-1:0]   = idx[ID_W-1:0];
            end
        end
        return res;
    endfunction

    // Pointer for the next search: the requester after the one just served.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
        int n;
        n = (int'(id) + 1) % NUM_REQ;
        return n[ID_W-1:0];
    endfunction

    assign {win_found, win_idx} = rr_pick(up_req_valid, rr_ptr);
    assign owner_oh             = NUM_REQ'(1) << owner_id;

    // Handshake strobes, one per state transition.
    assign accept    = (state == ARB_IDLE) && win_found;
    assign issue_hs  = (state == ARB_ISSUE) && dn_req_valid && dn_req_ready;
    assign resp_cap  = (state == ARB_WAIT_RESP) && dn_resp_valid;
    assign resp_done = (state == ARB_RESP) && |(up_resp_ready & owner_oh);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (accept) begin
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (issue_hs) begin
                    state_nxt = ARB_WAIT_RESP;
                end
            end
            ARB_WAIT_RESP: begin
                if (resp_cap) begin
                    state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (resp_done) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Output logic. up_req_ready is masked during reset: an accept on a
    // reset edge would be discarded and the request silently lost.
    always_comb begin
        up_req_ready  = '0;
        up_resp_valid = '0;
        dn_resp_ready = 1'b0;
        busy          = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (win_found && !rst) begin
                    up_req_ready = NUM_REQ'(1) << win_idx;
                end
            end
            ARB_ISSUE: begin
                busy = 1'b1;
            end
            ARB_WAIT_RESP: begin
                busy          = 1'b1;
                dn_resp_ready = 1'b1;
            end
            ARB_RESP: begin
                busy          = 1'b1;
                up_resp_valid = owner_oh;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Registered payloads, owner and round-robin pointer. Payloads only
    // change on their capture strobes and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_req_valid    <= 1'b0;
            dn_req_payload  <= '0;
            up_resp_payload <= '0;
            owner_id        <= '0;
            rr_ptr          <= '0;
        end else begin
            if (accept) begin
                dn_req_payload <= up_req_payload[win_idx];
                owner_id       <= win_idx;
                dn_req_valid   <= 1'b1;
            end else if (issue_hs) begin
                dn_req_valid   <= 1'b0;
            end
            if (resp_cap) begin
                up_resp_payload <= dn_resp_payload;
            end
            if (resp_done) begin
                rr_ptr <= rr_next(owner_id);
            end
        end
    end

endmodule

// File: tb/tb_bus_bridge_req_arbiter.sv
module tb_bus_bridge_req_arbiter;
    import bus_bridge_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     up_req_valid;
    logic [N-1:0]     up_req_ready;
    bus_bridge_req_t  up_req_payload [N];
    logic [N-1:0]     up_resp_valid;
    logic [N-1:0]     up_resp_ready;
    bus_bridge_resp_t up_resp_payload;
    logic             dn_req_valid;
    logic             dn_req_ready;
    bus_bridge_req_t  dn_req_payload;
    logic             dn_resp_valid;
    logic             dn_resp_ready;
    bus_bridge_resp_t dn_resp_payload;
    logic [IW-1:0]    owner_id;
    logic             busy;

    always #5 clk = ~clk;

    bus_bridge_req_arbiter #(.NUM_REQ(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .up_req_valid   (up_req_valid),
        .up_req_ready   (up_req_ready),
        .up_req_payload (up_req_payload),
        .up_resp_valid  (up_resp_valid),
        .up_resp_ready  (up_resp_ready),
        .up_resp_payload(up_resp_payload),
        .dn_req_valid   (dn_req_valid),
        .dn_req_ready   (dn_req_ready),
        .dn_req_payload (dn_req_payload),
        .dn_resp_valid  (dn_resp_valid),
        .dn_resp_ready  (dn_resp_ready),
        .dn_resp_payload(dn_resp_payload),
        .owner_id       (owner_id),
        .busy           (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: one record for the transaction in flight.
    bit               m_active;
    bit               m_sent;
    bit               m_answered;
    int               m_owner;
    int               m_ptr;
    bus_bridge_req_t  m_req;
    bus_bridge_resp_t m_resp;

    int dut_grants[$];
    int dnv_cycles;
    int resp1_cycles;

    function automatic int rr_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bus_bridge_req_t rand_req();
        bus_bridge_req_t r;
        r.addr       = $urandom;
        r.write_data = $urandom;
        r.is_write   = 1'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        m_active   = 0;
        m_sent     = 0;
        m_answered = 0;
        m_owner    = 0;
        m_ptr      = 0;
        m_req      = '0;
        m_resp     = '0;
    endtask

    // Called right after a falling edge with inputs already driven: checks
    // every output against the model, advances the model across the next
    // rising edge, and returns at the following falling edge.
    task automatic tick();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        int           w;
        #1;
        w       = rr_winner(up_req_valid, m_ptr);
        exp_rdy = (!rst && !m_active && w >= 0) ? (4'(1) << w) : 4'b0;
        exp_rv  = (m_active && m_answered) ? (4'(1) << m_owner) : 4'b0;
        check_val("up_req_ready", 128'(up_req_ready), 128'(exp_rdy));
        check_val("ready_onehot", 128'($countones(up_req_ready) <= 1), 128'(1));
        check_val("dn_req_valid", 128'(dn_req_valid), 128'(m_active && !m_sent));
        check_val("dn_req_payload", 128'(dn_req_payload), 128'(m_req));
        check_val("dn_resp_ready", 128'(dn_resp_ready), 128'(m_active && m_sent && !m_answered));
        check_val("up_resp_valid", 128'(up_resp_valid), 128'(exp_rv));
        check_val("up_resp_payload", 128'(up_resp_payload), 128'(m_resp));
        check_val("owner_id", 128'(owner_id), 128'(m_owner));
        check_val("busy", 128'(busy), 128'(m_active));
        for (int k = 0; k < N; k++) begin
            if (up_req_ready[k]) dut_grants.push_back(k);
        end
        if (dn_req_valid) dnv_cycles++;
        if (up_resp_valid[1]) resp1_cycles++;

        if (rst) begin
            model_reset();
        end else if (!m_active) begin
            if (w >= 0) begin
                m_active   = 1;
                m_sent     = 0;
                m_answered = 0;
                m_owner    = w;
                m_req      = up_req_payload[w];
            end
        end else if (!m_sent) begin
            if (dn_req_ready) m_sent = 1;
        end else if (!m_answered) begin
            if (dn_resp_valid) begin
                m_answered = 1;
                m_resp     = dn_resp_payload;
            end
        end else if (up_resp_ready[m_owner]) begin
            m_active = 0;
            m_ptr    = (m_owner + 1) % N;
        end
        @(negedge clk);
    endtask

    task automatic bridge_auto();
        dn_req_ready  = 1'b1;
        dn_resp_valid = 1'b1;
        up_resp_ready = '1;
    endtask

    task automatic drain(input string tag);
        int n;
        up_req_valid = '0;
        bridge_auto();
        n = 0;
        while (m_active && n < 20) begin
            tick();
            n++;
        end
        check_val(tag, 128'(m_active), 128'(0));
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int exp2 [6] = '{0, 1, 2, 3, 0, 1};
        int exp4 [3] = '{1, 3, 1};

        rst           = 1'b1;
        up_req_valid  = '0;
        up_resp_ready = '0;
        dn_req_ready  = 1'b0;
        dn_resp_valid = 1'b0;
        dn_resp_payload = '0;
        for (int i = 0; i < N; i++) up_req_payload[i] = rand_req();
        @(negedge clk);
        model_reset();
        tick();
        rst = 1'b0;
        #1;
        check_val("reset_dn_req_payload", 128'(dn_req_payload), 128'(0));
        check_val("reset_up_resp_payload", 128'(up_resp_payload), 128'(0));
        check_val("reset_busy", 128'(busy), 128'(0));
        tick();

        // Single write from requester 2
        up_req_valid = 4'b0100;
        up_req_payload[2] = '{addr: 32'h1234, write_data: 32'hA5, is_write: 1'b1};
        dn_req_ready = 1'b1;
        #1;
        check_val("t1_ready", 128'(up_req_ready), 128'(4'b0100));
        tick();
        up_req_valid = '0;
        up_req_payload[2] = rand_req();
        #1;
        check_val("t1_dn_valid", 128'(dn_req_valid), 128'(1));
        check_val("t1_dn_payload", 128'(dn_req_payload),
                  128'({32'h1234, 32'hA5, 1'b1}));
        check_val("t1_owner", 128'(owner_id), 128'(2));
        tick();
        dn_resp_valid   = 1'b1;
        dn_resp_payload = '{read_data: 32'h0, is_write: 1'b1};
        tick();
        dn_resp_valid = 1'b0;
        #1;
        check_val("t1_resp_valid", 128'(up_resp_valid), 128'(4'b0100));
        check_val("t1_resp_payload", 128'(up_resp_payload), 128'({32'h0, 1'b1}));
        up_resp_ready = 4'b0100;
        tick();
        up_resp_ready = '0;
        tick();

        // All requesters continuously valid from reset
        do_reset();
        dut_grants.delete();
        up_req_valid = 4'b1111;
        bridge_auto();
        n = 0;
        while (dut_grants.size() < 6 && n < 100) begin
            tick();
            n++;
        end
        check_val("t2_grant_count", 128'(dut_grants.size() >= 6), 128'(1));
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("t2_grant%0d", i),
                      128'(dut_grants.size() > i ? dut_grants[i] : -1), 128'(exp2[i]));
        end
        drain("t2_drain");

        // Read from requester 1 with downstream and upstream stalls
        do_reset();
        dnv_cycles    = 0;
        resp1_cycles  = 0;
        up_req_valid  = 4'b0010;
        up_req_payload[1] = '{addr: 32'h40, write_data: 32'h0, is_write: 1'b0};
        dn_req_ready  = 1'b0;
        dn_resp_valid = 1'b0;
        up_resp_ready = '0;
        tick();
        up_req_valid = '0;
        repeat (5) tick();
        dn_req_ready = 1'b1;
        tick();
        dn_req_ready    = 1'b0;
        dn_resp_valid   = 1'b1;
        dn_resp_payload = '{read_data: 32'h3C, is_write: 1'b0};
        tick();
        dn_resp_valid = 1'b0;
        #1;
        check_val("t3_read_data", 128'(up_resp_payload.read_data), 128'(32'h3C));
        repeat (3) tick();
        up_resp_ready = 4'b0010;
        tick();
        up_resp_ready = '0;
        tick();
        check_val("t3_dn_valid_cycles", 128'(dnv_cycles), 128'(6));
        check_val("t3_resp_cycles", 128'(resp1_cycles), 128'(4));

        // Requester 3 arrives while requester 1 is served
        dut_grants.delete();
        up_req_valid = 4'b0010;
        bridge_auto();
        tick();
        up_req_valid = 4'b1010;
        n = 0;
        while (dut_grants.size() < 3 && n < 60) begin
            tick();
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("t4_grant%0d", i),
                      128'(dut_grants.size() > i ? dut_grants[i] : -1), 128'(exp4[i]));
        end
        drain("t4_drain");

        // Reset while waiting for the bridge response
        up_req_valid  = 4'b0100;
        dn_req_ready  = 1'b1;
        dn_resp_valid = 1'b0;
        up_resp_ready = '0;
        tick();
        up_req_valid = '0;
        tick();
        #1;
        check_val("t5_in_wait", 128'(dn_resp_ready), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_val("t5_busy", 128'(busy), 128'(0));
        check_val("t5_dn_resp_ready", 128'(dn_resp_ready), 128'(0));
        check_val("t5_owner", 128'(owner_id), 128'(0));
        up_req_valid = 4'b0101;
        #1;
        check_val("t5_winner", 128'(up_req_ready), 128'(4'b0001));
        tick();
        drain("t5_drain");

        // Stray bridge responses outside the wait state
        dn_resp_valid   = 1'b1;
        dn_resp_payload = '{read_data: 32'hDEAD, is_write: 1'b1};
        dn_req_ready    = 1'b0;
        up_req_valid    = '0;
        #1;
        check_val("t6_idle_rdy", 128'(dn_resp_ready), 128'(0));
        tick();
        up_req_valid = 4'b1000;
        tick();
        up_req_valid = '0;
        #1;
        check_val("t6_issue_rdy", 128'(dn_resp_ready), 128'(0));
        check_val("t6_issue_rv", 128'(up_resp_valid), 128'(0));
        tick();
        dn_resp_valid = 1'b0;
        #1;
        check_val("t6_still_issue", 128'(dn_req_valid), 128'(1));
        drain("t6_drain");

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 199) == 0);
            up_req_valid  = 4'($urandom);
            for (int i = 0; i < N; i++) up_req_payload[i] = rand_req();
            dn_req_ready  = ($urandom_range(0, 2) != 0);
            dn_resp_valid = 1'($urandom);
            dn_resp_payload = '{read_data: $urandom, is_write: 1'($urandom)};
            up_resp_ready = 4'($urandom);
            tick();
        end
        rst = 1'b0;
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
